bcd_countdown_timer: RTL

//   Countdown counterpart of the stopwatch's up-counting datapath: holds an MM:SS value as
//   4 BCD digits and decrements by one second per prescaled tick, with BCD borrow.

---
 rtl/bcd_countdown_timer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// MM:SS countdown timer on four BCD digits, one decrement per CLK_DIV clocks, with expiry flagging.
// Optional feature: define AUTO_RELOAD_EN to reload the last loaded value on expiry instead of stopping.
module bcd_countdown_timer #(
  parameter int CLK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start_stop,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        done_pulse
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   prescaler;
  logic            load_ok, tick, expire, reload_hit;
  logic [15:0]     load_clamped, dec_val, reload_digits;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Digits above 9 saturate to 9; tens of seconds saturate to 5.
  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    return {clamp_digit(v[15:12], 4'd9), clamp_digit(v[11:8], 4'd9),
            clamp_digit(v[7:4], 4'd5), clamp_digit(v[3:0], 4'd9)};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] tm, m, ts, s;
    {tm, m, ts, s} = v;
    if (s != 4'd0) s = s - 4'd1;
    else begin
      s = 4'd9;
      if (ts != 4'd0) ts = ts - 4'd1;
      else begin
        ts = 4'd5;
        if (m != 4'd0) m = m - 4'd1;
        else begin
          m  = 4'd9;
          tm = tm - 4'd1;
        end
      end
    end
    return {tm, m, ts, s};
  endfunction

  assign load_ok      = load && (state != RUN);
  assign load_clamped = clamp_bcd(load_val);
  assign tick         = (state == RUN) && (prescaler == PW'(CLK_DIV - 1));
  assign dec_val      = bcd_dec(digits);
  assign expire       = tick && (dec_val == 16'h0000);

`ifdef AUTO_RELOAD_EN
  logic [15:0] reload_val;

  always_ff @(posedge clk) begin
    if (reset)        reload_val <= 16'h0000;
    else if (load_ok) reload_val <= load_clamped;
  end

  assign reload_digits = reload_val;
  assign reload_hit    = (reload_val != 16'h0000);
`else
  assign reload_digits = 16'h0000;
  assign reload_hit    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: assign a default before any branch so always_comb never infers a latch.
  always_comb begin
    state_next = state;
    if (load_ok) state_next = IDLE;
    else begin
      case (state)
        IDLE:    if (start_stop && digits != 16'h0000) state_next = RUN;
        RUN:     if (expire)          state_next = reload_hit ? RUN : DONE;
                 else if (start_stop) state_next = PAUSE;
        PAUSE:   if (start_stop) state_next = RUN;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb running = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      digits     <= 16'h0000;
      prescaler  <= '0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (load_ok) begin
        digits    <= load_clamped;
        prescaler <= '0;
        done      <= 1'b0;
      end else if (state == RUN) begin
        if (tick) begin
          prescaler <= '0;
          if (expire) begin
            // With a nonzero reload value the count restarts and done stays low.
            digits     <= reload_digits;
            done       <= !reload_hit;
            done_pulse <= 1'b1;
          end else begin
            digits <= dec_val;
          end
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end

endmodule
